// File: rtl/dac_playback.sv
// dac_playback: AXI-lite write-only sample RAM with a streaming playback engine.
//
// An AXI-lite slave fills a 2^ADDR_SIZE x WORD_SIZE RAM (byte strobes honoured).
// When enabled, the playback engine streams RAM[0 .. length-1] out on a
// valid/ready interface, optionally looping, and reports busy/done status.
//
// Optional feature: define PLAYBACK_COUNT_EN to add the beat_count output, a
// saturating count of accepted output beats since the last start.
//
// Ports:
//   axi_clock        - single clock for the AXI slave and playback
//   rst              - asynchronous active-high reset (RAM contents kept)
//   S_AXI_AW*        - write address channel (word index AWADDR[ADDR_SIZE+1:2])
//   S_AXI_W*         - write data channel with per-byte strobes
//   S_AXI_B*         - write response channel (always OKAY)
//   configuration    - bit0 enable, bit1 loop
//   length           - words to play; 0 means the whole RAM
//   dout/dout_valid/dout_ready - output sample stream
//   busy, done       - playback status
//   beat_count       - (PLAYBACK_COUNT_EN only) accepted beats since start
module dac_playback #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned ADDR_SIZE = 11
) (
  input  logic                   axi_clock,
  input  logic                   rst,
  input  logic [31:0]            S_AXI_AWADDR,
  input  logic [2:0]             S_AXI_AWPROT,
  input  logic                   S_AXI_AWVALID,
  output logic                   S_AXI_AWREADY,
  input  logic [WORD_SIZE-1:0]   S_AXI_WDATA,
  input  logic [WORD_SIZE/8-1:0] S_AXI_WSTRB,
  input  logic                   S_AXI_WVALID,
  output logic                   S_AXI_WREADY,
  output logic [1:0]             S_AXI_BRESP,
  output logic                   S_AXI_BVALID,
  input  logic                   S_AXI_BREADY,
  input  logic [31:0]            configuration,
  input  logic [ADDR_SIZE-1:0]   length,
  output logic [WORD_SIZE-1:0]   dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   busy,
  output logic                   done
`ifdef PLAYBACK_COUNT_EN
  ,
  output logic [31:0]            beat_count
`endif
);

  localparam int unsigned NumBytes = WORD_SIZE / 8;
  localparam int unsigned Depth    = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE-1:0] AddrOne = 1;

  typedef enum logic [1:0] {StIdle, StPrime, StRun, StDone} state_e;

  logic                  enable;
  logic                  loop;
  assign enable = configuration[0];
  assign loop   = configuration[1];

  // Protection and out-of-range address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_AWADDR[31:ADDR_SIZE+2], S_AXI_AWADDR[1:0],
                         configuration[31:2]};

  // ---------------------------------------------------------------------------
  // AXI-lite write slave: one-entry AW and W holding registers
  // ---------------------------------------------------------------------------
  logic                  aw_full_q;
  logic [ADDR_SIZE-1:0]  aw_idx_q;
  logic                  w_full_q;
  logic [WORD_SIZE-1:0]  w_data_q;
  logic [NumBytes-1:0]   w_strb_q;
  logic                  bvalid_q;
  logic                  wr_fire;

  // Nothing new is taken while a response is outstanding.
  assign S_AXI_AWREADY = !aw_full_q && !bvalid_q;
  assign S_AXI_WREADY  = !w_full_q && !bvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign wr_fire       = aw_full_q && w_full_q;

  always_ff @(posedge axi_clock or posedge rst) begin
    if (rst) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
    end else begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= S_AXI_AWADDR[ADDR_SIZE+1:2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_full_q <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      // Readies are low while both registers are full, so no capture can race this.
      if (wr_fire) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bvalid_q  <= 1'b1;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sample RAM: byte-write port, registered read port (read-first on collision)
  // ---------------------------------------------------------------------------
  logic [WORD_SIZE-1:0]  mem [Depth];
  logic                  rd_en;
  logic [ADDR_SIZE-1:0]  rd_addr;
  logic [WORD_SIZE-1:0]  dout_q;

  always_ff @(posedge axi_clock) begin
    if (wr_fire) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (w_strb_q[b]) begin
          mem[aw_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
        end
      end
    end
  end

  // The read data register doubles as the output register; holding rd_en low
  // keeps dout stable during a stall.
  always_ff @(posedge axi_clock or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
    end else if (rd_en) begin
      dout_q <= mem[rd_addr];
    end
  end

  assign dout = dout_q;

  // ---------------------------------------------------------------------------
  // Playback FSM
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [ADDR_SIZE-1:0]  ptr_q, ptr_d;
  logic [ADDR_SIZE-1:0]  len_q, len_d;
  logic                  valid_q, valid_d;
  logic [ADDR_SIZE-1:0]  last_idx;

  // length 0 wraps to all-ones, i.e. the full RAM.
  assign last_idx = len_q - AddrOne;

  always_ff @(posedge axi_clock or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    valid_d = valid_q;
    rd_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        if (enable) begin
          len_d   = length;
          ptr_d   = '0;
          state_d = StPrime;
        end
      end
      StPrime: begin
        if (!enable) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end else begin
          rd_en   = 1'b1;
          ptr_d   = '0;
          valid_d = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (!enable) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end else if (!valid_q || dout_ready) begin
          if (valid_q && ptr_q == last_idx) begin
            if (loop) begin
              ptr_d = '0;
              rd_en = 1'b1;
            end else begin
              valid_d = 1'b0;
              state_d = StDone;
            end
          end else begin
            ptr_d   = valid_q ? ptr_q + AddrOne : ptr_q;
            rd_en   = 1'b1;
            valid_d = 1'b1;
          end
        end
      end
      StDone: begin
        valid_d = 1'b0;
        if (!enable) begin
          state_d = StIdle;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // Fetch the word the pointer will hold next cycle.
  assign rd_addr    = ptr_d;
  assign dout_valid = valid_q;
  assign busy       = (state_q == StPrime) || (state_q == StRun);
  assign done       = (state_q == StDone);

`ifdef PLAYBACK_COUNT_EN
  always_ff @(posedge axi_clock or posedge rst) begin
    if (rst) begin
      beat_count <= '0;
    end else if (state_q == StIdle && state_d == StPrime) begin
      beat_count <= '0;
    end else if (dout_valid && dout_ready && beat_count != 32'hFFFF_FFFF) begin
      beat_count <= beat_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_playback.sv
// Self-checking bench for dac_playback: directed scenarios plus randomized
// RAM contents and ready patterns, checked against a word-array memory model.
module tb_dac_playback;

  localparam int Depth = 2048;

  logic        axi_clock = 1'b0;
  logic        rst;
  logic [31:0] S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] configuration;
  logic [10:0] length;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;
  logic        done;
`ifdef PLAYBACK_COUNT_EN
  logic [31:0] beat_count;
`endif

  dac_playback dut (
    .axi_clock     (axi_clock),
    .rst           (rst),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .configuration (configuration),
    .length        (length),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .busy          (busy),
`ifdef PLAYBACK_COUNT_EN
    .done          (done),
    .beat_count    (beat_count)
`else
    .done          (done)
`endif
  );

  always #5 axi_clock = ~axi_clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference RAM image, maintained from the writes the bench issues.
  logic [31:0] ref_mem [Depth];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_clock);
    #1;
  endtask

  // One AXI-lite write; W leads AW by w_lead cycles, BREADY held low b_hold cycles.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input int b_hold);
    int cyc;
    bit aw_done, w_done, aw_hs, w_hs;
    int idx;
    idx = int'(addr[12:2]);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
    end
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_WVALID  = 1'b1;
    S_AXI_AWADDR  = addr;
    S_AXI_AWPROT  = 3'($urandom);
    S_AXI_BREADY  = 1'b0;
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    while (!(aw_done && w_done) && cyc < 64) begin
      if (cyc >= w_lead && !aw_done) S_AXI_AWVALID = 1'b1;
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      if (aw_hs) begin
        aw_done = 1'b1;
        S_AXI_AWVALID = 1'b0;
      end
      if (w_hs) begin
        w_done = 1'b1;
        S_AXI_WVALID = 1'b0;
      end
      cyc++;
    end
    check("aw_w_accepted", {30'd0, aw_done, w_done}, 32'd3);
    cyc = 0;
    while (!S_AXI_BVALID && cyc < 8) begin
      tick();
      cyc++;
    end
    check("bvalid_seen", S_AXI_BVALID, 1);
    check("bresp_okay", S_AXI_BRESP, 0);
    for (int i = 0; i < b_hold; i++) begin
      tick();
      check("bvalid_hold", S_AXI_BVALID, 1);
      check("awready_blocked", S_AXI_AWREADY, 0);
      check("wready_blocked", S_AXI_WREADY, 0);
    end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check("bvalid_single", S_AXI_BVALID, 0);
    check("awready_back", S_AXI_AWREADY, 1);
  endtask

  // Start playback and check nbeats accepted words against the model.
  // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: random ready.
  task automatic run_play(input int len_val, input bit lp, input int nbeats, input int mode);
    int l_eff, beats, exp_idx, cyc;
    bit rdy;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    l_eff = (len_val == 0) ? Depth : len_val;
    length = 11'(len_val);
    configuration = {30'd0, lp, 1'b1};
    dout_ready = 1'b0;
    tick();
    check("prime_valid", dout_valid, 0);
    check("prime_busy", busy, 1);
    tick();
    beats   = 0;
    exp_idx = 0;
    cyc     = 0;
    while (beats < nbeats && cyc < nbeats * 8 + 20) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[cyc % 4];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      dout_ready = rdy;
      check("run_valid", dout_valid, 1);
      check("run_dout", dout, ref_mem[exp_idx]);
      tick();
      if (rdy) begin
        beats++;
        exp_idx = (exp_idx + 1) % l_eff;
      end
      cyc++;
    end
    check("beats_done", beats, nbeats);
    dout_ready = 1'b0;
    if (!lp) begin
      check("done_flag", done, 1);
      check("done_valid", dout_valid, 0);
      check("done_busy", busy, 0);
    end
    configuration = 32'd0;
    tick();
    check("idle_valid", dout_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
  endtask

  initial begin
    rst           = 1'b1;
    S_AXI_AWADDR  = '0;
    S_AXI_AWPROT  = '0;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0;
    S_AXI_WSTRB   = '0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    configuration = '0;
    length        = '0;
    dout_ready    = 1'b0;

    #12;
    check("rst_awready", S_AXI_AWREADY, 1);
    check("rst_wready", S_AXI_WREADY, 1);
    check("rst_bvalid", S_AXI_BVALID, 0);
    check("rst_bresp", S_AXI_BRESP, 0);
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef PLAYBACK_COUNT_EN
    check("rst_beat_count", beat_count, 0);
`endif
    rst = 1'b0;
    tick();

    // Three-word sequence: one-shot, looped, and stalled.
    axi_write(32'h0, 32'h1111_1111, 4'hF, 0, 0);
    axi_write(32'h4, 32'h2222_2222, 4'hF, 0, 0);
    axi_write(32'h8, 32'h3333_3333, 4'hF, 0, 0);
    run_play(3, 1'b0, 3, 0);
    run_play(3, 1'b1, 6, 0);
    run_play(3, 1'b0, 3, 1);

    // Partial byte strobe with W leading AW; response held for two cycles.
    axi_write(32'h0, 32'hAABB_CCDD, 4'b0010, 3, 2);
    run_play(1, 1'b0, 1, 0);
    check("strobe_merge_ref", ref_mem[0], {ref_mem[0][31:16], 8'hCC, ref_mem[0][7:0]});

    // Fill the whole RAM, then scatter partial writes through aliased addresses.
    for (int i = 0; i < Depth; i++) begin
      axi_write({19'd0, 11'(i), 2'b00}, $urandom, 4'hF, 0, 0);
    end
    for (int i = 0; i < 16; i++) begin
      axi_write({19'($urandom), 11'($urandom_range(0, 63)), 2'($urandom)},
                $urandom, 4'($urandom), $urandom_range(0, 2), 0);
    end

    // length 0 plays the full RAM once.
    run_play(0, 1'b0, Depth, 0);

    // Random lengths, loop settings and ready patterns.
    for (int r = 0; r < 4; r++) begin
      int len_r;
      bit lp_r;
      len_r = $urandom_range(1, 40);
      lp_r  = 1'($urandom_range(0, 1));
      run_play(len_r, lp_r, lp_r ? 2 * len_r + 3 : len_r, 2);
    end

    // Enable dropped in RUN after two beats, then restart from address 0.
    length        = 11'd8;
    configuration = 32'd1;
    dout_ready    = 1'b1;
    tick();
    tick();
    check("drop_beat0", dout, ref_mem[0]);
    tick();
    check("drop_beat1", dout, ref_mem[1]);
    tick();
    configuration = 32'd0;
    dout_ready    = 1'b0;
`ifdef PLAYBACK_COUNT_EN
    check("drop_beat_count", beat_count, 2);
`endif
    tick();
    check("drop_valid", dout_valid, 0);
    check("drop_busy", busy, 0);
    check("drop_done", done, 0);
    configuration = 32'd1;
    dout_ready    = 1'b1;
    tick();
    check("restart_prime_valid", dout_valid, 0);
`ifdef PLAYBACK_COUNT_EN
    check("restart_beat_count", beat_count, 0);
`endif
    configuration = 32'd0;
    dout_ready    = 1'b0;
    configuration = 32'd1;
    tick();
    check("restart_valid", dout_valid, 1);
    check("restart_dout", dout, ref_mem[0]);
    configuration = 32'd0;
    tick();
    check("restart_stop_valid", dout_valid, 0);

    // Reset with an address held and no data: holding register must be dropped.
    S_AXI_AWADDR  = 32'h10;
    S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    check("aw_held", S_AXI_AWREADY, 0);
    rst = 1'b1;
    #1;
    check("midrst_awready", S_AXI_AWREADY, 1);
    check("midrst_wready", S_AXI_WREADY, 1);
    check("midrst_bvalid", S_AXI_BVALID, 0);
    #1;
    rst = 1'b0;
    tick();
    tick();
    check("midrst_no_bvalid", S_AXI_BVALID, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
